// File: rtl/mips_lsu_pkg.sv
// rtl/mips_lsu_pkg.sv - shared types and helpers for the MIPS load/store unit
package mips_lsu_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } lsu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam int unsigned TIMEOUT_W = 16;

  function automatic logic is_store(lsu_op_e op);
    is_store = (op == SB) || (op == SH) || (op == SW);
  endfunction

  // Halfwords need addr[0]=0, words need addr[1:0]=0, bytes are always aligned.
  function automatic logic misaligned(lsu_op_e op, logic [1:0] addr_lo);
    case (op)
      LB, LBU, SB: misaligned = 1'b0;
      LH, LHU, SH: misaligned = addr_lo[0];
      default:     misaligned = |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/mips_lsu_if.sv
// rtl/mips_lsu_if.sv - core request/response and data memory signals of the LSU
interface mips_lsu_if;
  import mips_lsu_pkg::*;

  logic        req_valid;
  lsu_op_e     req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        excpt_adel;
  logic        excpt_ades;
  logic        excpt_dbe;
  logic [31:0] bad_addr;
  logic [29:0] mem_addr;
  logic        mem_rd_en;
  logic [3:0]  mem_write_en;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_ack;
  logic        mem_excpt;

  // Core plus memory side: drives requests and memory replies.
  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_data_out, mem_ack, mem_excpt,
    input  stall, resp_valid, resp_rdata, excpt_adel, excpt_ades, excpt_dbe, bad_addr,
    input  mem_addr, mem_rd_en, mem_write_en, mem_data_in
  );

  // The load/store unit itself.
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_data_out, mem_ack, mem_excpt,
    output stall, resp_valid, resp_rdata, excpt_adel, excpt_ades, excpt_dbe, bad_addr,
    output mem_addr, mem_rd_en, mem_write_en, mem_data_in
  );

endinterface

// File: rtl/mips_lsu_lane.sv
// rtl/mips_lsu_lane.sv - byte-lane masks, store replication and load extension
module mips_lsu_lane
  import mips_lsu_pkg::*;
(
  input  lsu_op_e     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  write_en,
  output logic [31:0] data_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword out of the little-endian read word.
  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Per-op lane mask, replicated store data and extended load data.
  always_comb begin
    write_en  = 4'b0000;
    data_rep  = 32'd0;
    rdata_ext = 32'd0;
    case (op)
      LB:  rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      LBU: rdata_ext = {24'd0, byte_sel};
      LH:  rdata_ext = {{16{half_sel[15]}}, half_sel};
      LHU: rdata_ext = {16'd0, half_sel};
      SB: begin
        write_en = 4'b0001 << addr_lo;
        data_rep = {4{wdata[7:0]}};
      end
      SH: begin
        write_en = 4'b0011 << addr_lo;
        data_rep = {2{wdata[15:0]}};
      end
      SW: begin
        write_en = 4'b1111;
        data_rep = wdata;
      end
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/mips_lsu.sv
// rtl/mips_lsu.sv - load/store unit top; optional bus timeout under MIPS_LSU_TIMEOUT_EN
module mips_lsu
  import mips_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_b,
  mips_lsu_if.slave  bus
);

  lsu_state_e  state_q;
  lsu_op_e     op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        adel_q;
  logic        ades_q;
  logic        dbe_q;
  logic [31:0] bad_addr_q;

  logic [3:0]  lane_we;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        busy;

`ifdef MIPS_LSU_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  logic [TIMEOUT_W-1:0] wait_cnt_q;
`endif

  mips_lsu_lane u_lane (
    .op        (op_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (bus.mem_data_out),
    .write_en  (lane_we),
    .data_rep  (lane_wdata),
    .rdata_ext (lane_rdata)
  );

  // Request FSM: accept/check in IDLE, wait on memory in BUSY, pulse result in DONE.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= IDLE;
      op_q         <= LW;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      adel_q       <= 1'b0;
      ades_q       <= 1'b0;
      dbe_q        <= 1'b0;
      bad_addr_q   <= 32'd0;
`ifdef MIPS_LSU_TIMEOUT_EN
      wait_cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            if (misaligned(bus.req_op, bus.req_addr[1:0])) begin
              state_q    <= DONE;
              bad_addr_q <= bus.req_addr;
              if (is_store(bus.req_op)) ades_q <= 1'b1;
              else                      adel_q <= 1'b1;
            end else begin
              state_q <= BUSY;
              op_q    <= bus.req_op;
              addr_q  <= bus.req_addr;
              wdata_q <= bus.req_wdata;
`ifdef MIPS_LSU_TIMEOUT_EN
              wait_cnt_q <= '0;
`endif
            end
          end
        end
        BUSY: begin
          if (bus.mem_excpt) begin
            state_q    <= DONE;
            dbe_q      <= 1'b1;
            bad_addr_q <= addr_q;
          end else if (bus.mem_ack) begin
            state_q      <= DONE;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= lane_rdata;
          end
`ifdef MIPS_LSU_TIMEOUT_EN
          else if (wait_cnt_q == TIMEOUT_LAST) begin
            state_q    <= DONE;
            dbe_q      <= 1'b1;
            bad_addr_q <= addr_q;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        default: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_rdata_q <= 32'd0;
          adel_q       <= 1'b0;
          ades_q       <= 1'b0;
          dbe_q        <= 1'b0;
          bad_addr_q   <= 32'd0;
        end
      endcase
    end
  end

  assign busy = (state_q == BUSY);

  // Reset gates stall so every output reads 0 while rst_b is low.
  assign bus.stall        = bus.req_valid & rst_b & (state_q != DONE);
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_rdata   = resp_rdata_q;
  assign bus.excpt_adel   = adel_q;
  assign bus.excpt_ades   = ades_q;
  assign bus.excpt_dbe    = dbe_q;
  assign bus.bad_addr     = bad_addr_q;
  assign bus.mem_addr     = busy ? addr_q[31:2] : 30'd0;
  assign bus.mem_rd_en    = busy & ~is_store(op_q);
  assign bus.mem_write_en = busy ? lane_we : 4'b0000;
  assign bus.mem_data_in  = busy ? lane_wdata : 32'd0;

endmodule

// File: doc/mips_lsu.md
# mips_lsu

Load/store unit between the single-cycle MIPS core's execute datapath and the data memory port. It accepts one load or store per instruction from the core and generates byte-lane write enables and store-data replication. It runs a handshake with a variable-latency data memory, stalling the core until completion, then returns sign- or zero-extended load data. It also flags address-error and data-bus-error exceptions for the exception unit.

## Interface
- `TIMEOUT_CYCLES`, default 255: BUSY cycles without `mem_ack` before a bus error is declared; only used under `MIPS_LSU_TIMEOUT_EN`.
- `clk` in 1: clock, rising-edge.
- `rst_b` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: the current instruction is a load or store; held high until the `DONE` cycle.
- `req_op` in 3: operation; one of LB, LBU, LH, LHU, LW, SB, SH, SW.
- `req_addr` in 32: effective byte address (ALU output).
- `req_wdata` in 32: store data (rt).
- `stall` out 1: high while a request is outstanding; freezes the PC and register-file write.
- `resp_valid` out 1: one-cycle pulse; the access completed without error.
- `resp_rdata` out 32: extended load data, valid with `resp_valid`; 0 for stores.
- `excpt_adel` out 1: misaligned load, one-cycle pulse.
- `excpt_ades` out 1: misaligned store, one-cycle pulse.
- `excpt_dbe` out 1: bus error, one-cycle pulse.
- `bad_addr` out 32: faulting address, valid with any `excpt_*` pulse.
- `mem_addr` out 30: word address, `req_addr[31:2]`.
- `mem_rd_en` out 1: read strobe.
- `mem_write_en` out 4: byte-lane write mask.
- `mem_data_in` out 32: store data, lane-replicated.
- `mem_data_out` in 32: read data.
- `mem_ack` in 1: memory completes the access this cycle.
- `mem_excpt` in 1: memory rejects the access this cycle.

## Operation
- **Byte order:** little-endian. Byte k = bits [8k+7:8k]. Write-enable bit k covers byte k.
- **States:** `IDLE`, `BUSY`, `DONE`.
- **`IDLE`, `req_valid` high:** check alignment first.
  - Halfword needs `addr[0]`=0. Word needs `addr[1:0]`=0.
  - Misaligned: go to `DONE` with the error latched (ADEL for loads, ADES for stores). No memory access is made.
  - Aligned: latch op, address and data, then go to `BUSY`.
- **`BUSY`:** drive memory outputs from the latched values.
  - Store masks: SB = `4'b0001<<addr[1:0]`; SH = `4'b0011<<addr[1:0]`; SW = `4'b1111`. Loads drive `mem_rd_en`=1 and mask 0.
  - Store data: SB replicates the byte ×4; SH replicates the half ×2.
  - On `mem_ack`: capture the extracted and extended lane, go to `DONE`.
  - On `mem_excpt`: latch DBE, go to `DONE`. If `mem_excpt` and `mem_ack` arrive together, `mem_excpt` wins.
- **`DONE`:** pulse exactly one of `resp_valid` / `excpt_adel` / `excpt_ades` / `excpt_dbe`. Drop `stall`. Always return to `IDLE`. `req_valid` is ignored in this cycle because the core retires the instruction on this edge.
- **`stall`:** equals `req_valid & (state != DONE)`, and is combinational from `req_valid` while in `IDLE`.
- **Memory outputs outside `BUSY`:** all zero.
- **Unused `req_op` encodings:** treated as LW.

## Timing
- **Reset:** all outputs 0, state `IDLE`. Reset asserted mid-`BUSY` abandons the access; no response pulse follows.
- **Minimum latency:** accept in cycle 0 (`IDLE`), `mem_ack` in cycle 1 (`BUSY`), result in cycle 2 (`DONE`). Each memory wait cycle adds 1.
- **Misaligned access:** result in cycle 1.
- **Back-to-back requests:** the next request is accepted in the cycle after `DONE`. Throughput is at most one access per 3 cycles.
- **Held inputs:** `mem_addr`, `mem_write_en` and `mem_data_in` stay stable for the whole `BUSY` interval.

## Configuration
- **`MIPS_LSU_TIMEOUT_EN` defined:** an 8..16-bit counter clears on entry to `BUSY` and increments each `BUSY` cycle without ack. When it reaches `TIMEOUT_CYCLES`, DBE is raised via `DONE`.
- **Undefined:** no counter; `BUSY` waits indefinitely for `mem_ack`/`mem_excpt`.

## Structure
- **Package `mips_lsu_pkg`:** the `req_op` enum (LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7) and the state enum.
- **Sub-module `mips_lsu_lane`:** combinational. Maps op and `addr[1:0]` to write mask and replicated store data, and extracts and extends load data. It is instantiated once in the top level.

## Test plan
- SB to 0x1000_0003 with data 0x0000_00A5, ack after 2 waits:
  - `mem_write_en`=1000, `mem_data_in`=A5A5A5A5, `mem_addr`=0x0400_0000.
  - `resp_valid` in cycle 4; `stall` high in cycles 0–3.
- LB from 0x1000_0002, memory returns 0x1180_7F22: `resp_rdata`=0xFFFF_FF80. Same access as LBU: 0x0000_0080.
- LH from 0x1000_0001: `excpt_adel` with `bad_addr`=0x1000_0001 in cycle 1; `mem_rd_en` never asserted. SW to 0x...2: `excpt_ades`.
- LW where `mem_excpt` and `mem_ack` fire together in cycle 1: `excpt_dbe` in cycle 2, `resp_valid` stays 0.
- With `MIPS_LSU_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, no ack: `excpt_dbe` after exactly 4 `BUSY` cycles.
- `rst_b` low mid-`BUSY`, then a new LW with zero wait: all outputs 0 during reset; the new LW's `resp_valid` arrives 2 cycles after acceptance.
